// File: rtl/spi_flash_responder.sv
// SPI flash-emulating slave: decodes READ (opcode + address) and streams bytes
// fetched through a req/ack memory port, prefetching one byte ahead.
`timescale 1ns/1ps
module spi_flash_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] READ_CMD    = 8'h03,
   parameter int         ADDR_BITS   = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spi_cs,
   input  logic                 spi_clk,
   input  logic                 spi_si,
   output logic                 spi_so,
   output logic                 spi_so_oe,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_req,
   input  logic                 mem_ack,
   input  logic [7:0]           mem_data,
   output logic                 busy,
   output logic                 cmd_err,
   output logic                 underrun
);

   localparam int CW = $clog2(ADDR_BITS) + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      DATA   = 3'd3,
      IGNORE = 3'd4
   } state_t;

   state_t                 state_r, next_state_s;
   logic [SYNC_STAGES-1:0] cs_sync_r, sclk_sync_r, si_sync_r;
   logic                   sclk_d_r;
   logic                   cs_s, sclk_s, si_s, rise_s, fall_s;
   logic [CW-1:0]          bit_cnt_r;
   logic [2:0]             phase_r;
   logic [ADDR_BITS-1:0]   in_sr_r;
   logic [7:0]             out_sr_r, buf_r;
   logic                   buf_full_r, req_next_r;
   logic [7:0]             cmd_byte_s;
   logic [ADDR_BITS-1:0]   addr_word_s;
   logic                   cmd_done_s, cmd_bad_s, addr_done_s;
   logic                   boundary_s, shift_s, ack_s, ack_take_s, oe_next_s;

   // Oversample the SPI pins; cs idles high so a fresh reset never sees a select
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_sync_r   <= '1;
         sclk_sync_r <= '0;
         si_sync_r   <= '0;
         sclk_d_r    <= 1'b0;
      end else begin
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs};
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_clk};
         si_sync_r   <= {si_sync_r[SYNC_STAGES-2:0], spi_si};
         sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
      end
   end

   assign cs_s   = cs_sync_r[SYNC_STAGES-1];
   assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
   assign si_s   = si_sync_r[SYNC_STAGES-1];
   assign rise_s = sclk_s & ~sclk_d_r;
   assign fall_s = ~sclk_s & sclk_d_r;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; a deselect wins over any simultaneous clock edge
   always_comb begin
      next_state_s = state_r;
      if (cs_s) begin
         next_state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    next_state_s = CMD;
            CMD:     next_state_s = cmd_done_s ? (cmd_bad_s ? IGNORE : ADDR) : CMD;
            ADDR:    next_state_s = addr_done_s ? DATA : ADDR;
            DATA:    next_state_s = DATA;
            IGNORE:  next_state_s = IGNORE;
            default: next_state_s = IDLE;
         endcase
      end
   end

   // Per-cycle events derived from the state and the SPI strobes
   always_comb begin
      cmd_byte_s  = {in_sr_r[6:0], si_s};
      addr_word_s = {in_sr_r[ADDR_BITS-2:0], si_s};
      cmd_done_s  = !cs_s && (state_r == CMD) && rise_s && (bit_cnt_r == CW'(7));
      cmd_bad_s   = cmd_done_s && (cmd_byte_s != READ_CMD);
      addr_done_s = !cs_s && (state_r == ADDR) && rise_s && (bit_cnt_r == CW'(ADDR_BITS - 1));
      boundary_s  = !cs_s && (state_r == DATA) && fall_s && (phase_r == 3'd0);
      shift_s     = !cs_s && (state_r == DATA) && fall_s && (phase_r != 3'd0);
      ack_s       = mem_ack && mem_req;
      ack_take_s  = ack_s && !cs_s && (state_r == DATA);
      oe_next_s   = (next_state_s == DATA);
   end

   // Datapath and registered outputs; an ack outside DATA is consumed and dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt_r  <= '0;
         phase_r    <= 3'd0;
         in_sr_r    <= '0;
         out_sr_r   <= 8'h00;
         buf_r      <= 8'h00;
         buf_full_r <= 1'b0;
         req_next_r <= 1'b0;
         spi_so     <= 1'b0;
         spi_so_oe  <= 1'b0;
         mem_addr   <= '0;
         mem_req    <= 1'b0;
         busy       <= 1'b0;
         cmd_err    <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         busy       <= ~cs_s;
         cmd_err    <= cmd_bad_s;
         underrun   <= 1'b0;
         spi_so_oe  <= oe_next_s;
         req_next_r <= 1'b0;
         if (ack_s) begin
            mem_req <= 1'b0;
         end
         if (cs_s) begin
            bit_cnt_r  <= '0;
            phase_r    <= 3'd0;
            buf_full_r <= 1'b0;
            out_sr_r   <= 8'h00;
            spi_so     <= 1'b0;
         end else begin
            if (rise_s && ((state_r == CMD) || (state_r == ADDR))) begin
               in_sr_r   <= addr_word_s;
               bit_cnt_r <= (cmd_done_s || addr_done_s) ? '0 : bit_cnt_r + CW'(1);
            end
            if (addr_done_s) begin
               mem_addr   <= addr_word_s;
               mem_req    <= 1'b1;
               phase_r    <= 3'd0;
               buf_full_r <= 1'b0;
            end
            if (req_next_r) begin
               mem_req <= 1'b1;
            end
            if (boundary_s) begin
               phase_r  <= 3'd1;
               mem_addr <= mem_addr + ADDR_BITS'(1);
               if (buf_full_r) begin
                  out_sr_r   <= buf_r;
                  spi_so     <= buf_r[7];
                  buf_full_r <= 1'b0;
                  mem_req    <= 1'b1;
               end else if (ack_take_s) begin
                  // Byte arrives exactly on time: bypass the buffer, refetch next clk
                  out_sr_r   <= mem_data;
                  spi_so     <= mem_data[7];
                  req_next_r <= 1'b1;
               end else begin
                  out_sr_r <= 8'hFF;
                  spi_so   <= 1'b1;
                  underrun <= 1'b1;
                  mem_req  <= 1'b1;
               end
            end else if (shift_s) begin
               phase_r  <= phase_r + 3'd1;
               out_sr_r <= {out_sr_r[6:0], 1'b0};
               spi_so   <= out_sr_r[6];
            end
            if (ack_take_s && !boundary_s) begin
               buf_r      <= mem_data;
               buf_full_r <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: an SPI master task drives randomized READ bursts and a
// behavioural memory/stream model predicts bytes, fetch addresses and pulses.
`timescale 1ns/1ps
module tb_spi_flash_responder;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_cs, spi_clk, spi_si;
   logic        spi_so, spi_so_oe;
   logic [23:0] mem_addr;
   logic        mem_req, mem_ack;
   logic [7:0]  mem_data;
   logic        busy, cmd_err, underrun;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          half = 8;
   logic [7:0]  seed = 8'h5A;
   logic [7:0]  ovr [logic [23:0]];
   int          ack_delay = 1, stall_idx = -1, long_delay = 0, req_idx = 0, wait_cnt = 0;
   int          underrun_cnt = 0, cmd_err_cnt = 0, req_rise_cnt = 0, oe_hi_cnt = 0, oe_miss = 0;
   logic        req_prev = 1'b0;
   logic [23:0] last_log = 24'h0;
   logic [23:0] addr_q[$];
   logic [7:0]  rx_q[$];
   bit          mst_abort = 1'b0;

   spi_flash_responder dut (
      .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_si(spi_si),
      .spi_so(spi_so), .spi_so_oe(spi_so_oe), .mem_addr(mem_addr), .mem_req(mem_req),
      .mem_ack(mem_ack), .mem_data(mem_data), .busy(busy), .cmd_err(cmd_err),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   // Reference memory contents
   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      if (ovr.exists(a)) return ovr[a];
      return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ seed;
   endfunction

   // Memory responder: acks after a per-request delay with the byte at the current address
   initial begin
      mem_ack = 1'b0;
      mem_data = 8'h00;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req === 1'b1) begin
            if (wait_cnt >= ((req_idx == stall_idx) ? long_delay : ack_delay)) begin
               mem_ack  = 1'b1;
               mem_data = mem_byte(mem_addr);
               wait_cnt = 0;
               req_idx++;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Event monitor: pulse counts and the sequence of requested addresses
   initial begin
      forever begin
         @(negedge clk);
         if (underrun === 1'b1) underrun_cnt++;
         if (cmd_err === 1'b1) cmd_err_cnt++;
         if (spi_so_oe === 1'b1) oe_hi_cnt++;
         if (mem_req === 1'b1 && !req_prev) req_rise_cnt++;
         if (mem_req === 1'b1 && (!req_prev || mem_addr != last_log)) begin
            addr_q.push_back(mem_addr);
            last_log = mem_addr;
         end
         req_prev = (mem_req === 1'b1);
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic clear_mon();
      underrun_cnt = 0; cmd_err_cnt = 0; req_rise_cnt = 0; oe_hi_cnt = 0;
      addr_q.delete(); rx_q.delete(); req_idx = 0; stall_idx = -1;
   endtask

   // Mode-0 master: header bits, then data bits sampled just before each rise
   task automatic spi_xfer(input logic [7:0] op, input logic [23:0] a, input int nbits);
      logic [31:0] hdr;
      logic [7:0]  cur;
      hdr = {op, a};
      cur = 8'h00;
      rx_q.delete();
      oe_miss = 0;
      spi_clk = 1'b0;
      spi_cs  = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         if (mst_abort) break;
         spi_si = (i < 32) ? hdr[31-i] : 1'($urandom_range(0, 1));
         repeat (half) @(negedge clk);
         if (i >= 32) begin
            cur = {cur[6:0], spi_so};
            if (spi_so_oe !== 1'b1) oe_miss++;
            if (((i - 32) % 8) == 7) rx_q.push_back(cur);
         end
         spi_clk = 1'b1;
         repeat (half) @(negedge clk);
         if (i == nbits - 1) spi_cs = 1'b1;
         spi_clk = 1'b0;
      end
      spi_cs  = 1'b1;
      spi_clk = 1'b0;
      spi_si  = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (mem_req === 1'b0 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; spi_cs = 1'b1; spi_clk = 1'b0; spi_si = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (spi_so !== 1'b0)     begin n_fail++; $display("FAIL reset_so: got %b expected 0", spi_so); end
      n_tests++; if (spi_so_oe !== 1'b0)  begin n_fail++; $display("FAIL reset_oe: got %b expected 0", spi_so_oe); end
      n_tests++; if (mem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req); end
      n_tests++; if (mem_addr !== 24'h0)  begin n_fail++; $display("FAIL reset_addr: got %h expected 000000", mem_addr); end
      n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++; if (cmd_err !== 1'b0)    begin n_fail++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
      n_tests++; if (underrun !== 1'b0)   begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
      reset = 1'b1;
      repeat (4) @(negedge clk);
      n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_read_basic();
      bit ok;
      logic [7:0] exp_b [2];
      exp_b[0] = 8'h23; exp_b[1] = 8'h89;
      ovr[24'h002002] = 8'h23;
      ovr[24'h002003] = 8'h89;
      clear_mon(); ack_delay = 1;
      spi_xfer(8'h03, 24'h002002, 48);
      wait_idle(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_idle: got busy/req stuck expected idle"); end
      n_tests++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL basic_nbytes: got %0d expected 2", rx_q.size()); end
      for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
         n_tests++; if (rx_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]); end
      end
      n_tests++; if (addr_q.size() != 3) begin n_fail++; $display("FAIL basic_addr_cnt: got %0d expected 3", addr_q.size()); end
      for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
         n_tests++; if (addr_q[i] !== 24'h002002 + 24'(i)) begin n_fail++; $display("FAIL basic_addr%0d: got %h expected %h", i, addr_q[i], 24'h002002 + 24'(i)); end
      end
      n_tests++; if (underrun_cnt != 0) begin n_fail++; $display("FAIL basic_underrun: got %0d expected 0", underrun_cnt); end
      n_tests++; if (oe_miss != 0) begin n_fail++; $display("FAIL basic_oe: got %0d low samples expected 0", oe_miss); end
   endtask

   task automatic test_bad_opcode();
      bit ok;
      logic [7:0] op;
      for (int k = 0; k < 3; k++) begin
         op = (k == 0) ? 8'h0B : 8'($urandom_range(4, 255));
         clear_mon();
         spi_xfer(op, 24'($urandom), 32);
         wait_idle(ok);
         n_tests++; if (cmd_err_cnt != 1) begin n_fail++; $display("FAIL badop_cmd_err op=%h: got %0d pulses expected 1", op, cmd_err_cnt); end
         n_tests++; if (oe_hi_cnt != 0)   begin n_fail++; $display("FAIL badop_oe op=%h: got %0d high cycles expected 0", op, oe_hi_cnt); end
         n_tests++; if (req_rise_cnt != 0) begin n_fail++; $display("FAIL badop_req op=%h: got %0d requests expected 0", op, req_rise_cnt); end
      end
   endtask

   task automatic test_read(input logic [23:0] a, input int n, input string tag);
      bit ok;
      clear_mon();
      spi_xfer(8'h03, a, 32 + 8 * n);
      wait_idle(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL %s_idle: got busy/req stuck expected idle", tag); end
      n_tests++; if (rx_q.size() != n) begin n_fail++; $display("FAIL %s_nbytes: got %0d expected %0d", tag, rx_q.size(), n); end
      for (int i = 0; i < n && i < rx_q.size(); i++) begin
         n_tests++; if (rx_q[i] !== mem_byte(a + 24'(i))) begin n_fail++; $display("FAIL %s_byte%0d: got %h expected %h", tag, i, rx_q[i], mem_byte(a + 24'(i))); end
      end
      n_tests++; if (addr_q.size() != n + 1) begin n_fail++; $display("FAIL %s_addr_cnt: got %0d expected %0d", tag, addr_q.size(), n + 1); end
      for (int i = 0; i <= n && i < addr_q.size(); i++) begin
         n_tests++; if (addr_q[i] !== a + 24'(i)) begin n_fail++; $display("FAIL %s_addr%0d: got %h expected %h", tag, i, addr_q[i], a + 24'(i)); end
      end
      n_tests++; if (underrun_cnt != 0) begin n_fail++; $display("FAIL %s_underrun: got %0d expected 0", tag, underrun_cnt); end
   endtask

   task automatic test_wrap();
      test_read(24'hFFFFFF, 2, "wrap");
   endtask

   task automatic test_underrun();
      bit ok;
      clear_mon();
      stall_idx = 0; long_delay = 3 * half;
      spi_xfer(8'h03, 24'h000000, 48);
      wait_idle(ok);
      n_tests++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL under_nbytes: got %0d expected 2", rx_q.size()); end
      if (rx_q.size() == 2) begin
         n_tests++; if (rx_q[0] !== 8'hFF) begin n_fail++; $display("FAIL under_byte0: got %h expected ff", rx_q[0]); end
         n_tests++; if (rx_q[1] !== mem_byte(24'h000001)) begin n_fail++; $display("FAIL under_byte1: got %h expected %h", rx_q[1], mem_byte(24'h000001)); end
      end
      n_tests++; if (underrun_cnt != 1) begin n_fail++; $display("FAIL under_pulse: got %0d expected 1", underrun_cnt); end
      n_tests++; if (addr_q.size() != 3 || addr_q[2] !== 24'h000002) begin n_fail++; $display("FAIL under_addr: got %0d entries expected 3 ending 000002", addr_q.size()); end
      stall_idx = -1;
   endtask

   task automatic test_cs_abort();
      bit ok;
      logic [23:0] a;
      a = 24'($urandom);
      clear_mon();
      stall_idx = 1; long_delay = 200;
      spi_xfer(8'h03, a, 36);
      repeat (SYNC + 2) @(negedge clk);
      n_tests++; if (spi_so_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe: got %b expected 0", spi_so_oe); end
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
      n_tests++; if (mem_req !== 1'b1)   begin n_fail++; $display("FAIL abort_req_held: got %b expected 1", mem_req); end
      n_tests++; if (mem_addr !== a + 24'd1) begin n_fail++; $display("FAIL abort_addr: got %h expected %h", mem_addr, a + 24'd1); end
      wait_idle(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_req_drop: got req stuck expected low after ack"); end
      repeat (5) @(negedge clk);
      n_tests++; if (mem_req !== 1'b0)   begin n_fail++; $display("FAIL abort_req_low: got %b expected 0", mem_req); end
      n_tests++; if (underrun_cnt != 0)  begin n_fail++; $display("FAIL abort_underrun: got %0d expected 0", underrun_cnt); end
      stall_idx = -1;
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         logic [23:0] a;
         int n;
         a = 24'($urandom);
         if ($urandom_range(0, 2) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 2));
         n = $urandom_range(1, 4);
         half = $urandom_range(8, 10);
         ack_delay = $urandom_range(0, 2);
         seed = 8'($urandom);
         test_read(a, n, "rand");
      end
      half = 8; ack_delay = 1;
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [23:0] a0, a1;
      logic [7:0] r0 [$];
      a0 = 24'($urandom); a1 = 24'($urandom);
      clear_mon();
      spi_xfer(8'h03, a0, 48);
      r0 = rx_q;
      repeat (half) @(negedge clk);
      spi_xfer(8'h03, a1, 40);
      wait_idle(ok);
      n_tests++; if (r0.size() != 2 || r0[0] !== mem_byte(a0) || r0[1] !== mem_byte(a0 + 24'd1)) begin
         n_fail++; $display("FAIL b2b_first: got %0d bytes expected %h %h", r0.size(), mem_byte(a0), mem_byte(a0 + 24'd1)); end
      n_tests++; if (rx_q.size() != 1 || rx_q[0] !== mem_byte(a1)) begin
         n_fail++; $display("FAIL b2b_second: got %0d bytes expected %h", rx_q.size(), mem_byte(a1)); end
      n_tests++; if (underrun_cnt != 0) begin n_fail++; $display("FAIL b2b_underrun: got %0d expected 0", underrun_cnt); end
   endtask

   task automatic test_reset_mid_burst();
      clear_mon();
      ovr[24'h002004] = 8'hC6;
      fork
         spi_xfer(8'h03, 24'h002002, 64);
         begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 3000; i++) begin
               @(negedge clk);
               if (mem_addr === 24'h002004) begin hit = 1'b1; break; end
            end
            n_tests++; if (!hit) begin n_fail++; $display("FAIL midrst_reach: got addr %h expected 002004", mem_addr); end
            reset = 1'b0;
            #1;
            n_tests++; if ({spi_so, spi_so_oe, mem_req, busy, cmd_err, underrun} !== 6'b0 || mem_addr !== 24'h0) begin
               n_fail++; $display("FAIL midrst_outputs: got so=%b oe=%b req=%b busy=%b addr=%h expected all 0",
                                  spi_so, spi_so_oe, mem_req, busy, mem_addr); end
            mst_abort = 1'b1;
         end
      join
      spi_cs = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      mst_abort = 1'b0;
      repeat (4) @(negedge clk);
      test_read(24'h000100, 2, "postrst");
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_bad_opcode();
      test_wrap();
      test_underrun();
      test_cs_abort();
      test_random();
      test_back_to_back();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
